// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the 2-bit-per-channel colour type and the
// fixed rectangle palette used by the animation engine.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [5:0] rgb222_t;

    // {R[1:0],G[1:0],B[1:0]}: red, green, blue, yellow, cyan, magenta, white, grey
    localparam rgb222_t PALETTE [8] = '{
        6'b11_00_00, 6'b00_11_00, 6'b00_00_11, 6'b11_11_00,
        6'b00_11_11, 6'b11_00_11, 6'b11_11_11, 6'b10_10_10
    };

endpackage

// File: rtl/vga_rect_mover.sv
// Position and direction state for one rectangle, advanced by one step on
// each move pulse in either bounce (x and y) or horizontal-wrap (x only) mode.
module vga_rect_mover
    import vga_pkg::*;
#(
    parameter int         RECT_W      = 64,
    parameter int         RECT_H      = 48,
    parameter int         STEP        = 2,
    parameter logic [9:0] INIT_X      = 10'd0,
    parameter logic [9:0] INIT_Y      = 10'd0,
    parameter logic       INIT_DY_NEG = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_move,
    input  logic       i_mode,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);

    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - RECT_W);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - RECT_H);
    localparam logic [10:0] STEP_W = 11'(STEP);

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_dx_neg;
    logic        r_dy_neg;
    logic [10:0] w_x_bounce;
    logic [10:0] w_y_bounce;
    logic [10:0] w_x_sum;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic        w_dx_next;
    logic        w_dy_next;

    // Returns {new direction (1 = negative), new position}; clamps at 0 / maxPos.
    function automatic logic [10:0] bounceAxis(input logic [9:0]  pos,
                                               input logic        neg,
                                               input logic [10:0] maxPos);
        logic [10:0] sum;
        logic [10:0] result;
        sum = {1'b0, pos} + STEP_W;
        if (!neg) begin
            if (sum >= maxPos) result = {1'b1, maxPos[9:0]};
            else               result = {1'b0, sum[9:0]};
        end else begin
            if ({1'b0, pos} <= STEP_W) result = {1'b0, 10'd0};
            else                       result = {1'b1, pos - STEP_W[9:0]};
        end
        return result;
    endfunction

    always_comb begin
        w_x_bounce = bounceAxis(r_x, r_dx_neg, XMAX);
        w_y_bounce = bounceAxis(r_y, r_dy_neg, YMAX);
        w_x_sum    = {1'b0, r_x} + STEP_W;
        if (i_mode) begin
            w_x_next  = (w_x_sum > XMAX) ? 10'd0 : w_x_sum[9:0];
            w_y_next  = r_y;
            w_dx_next = r_dx_neg;
            w_dy_next = r_dy_neg;
        end else begin
            w_x_next  = w_x_bounce[9:0];
            w_y_next  = w_y_bounce[9:0];
            w_dx_next = w_x_bounce[10];
            w_dy_next = w_y_bounce[10];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= INIT_X;
            r_y      <= INIT_Y;
            r_dx_neg <= 1'b0;
            r_dy_neg <= INIT_DY_NEG;
        end else if (i_move) begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_dx_neg <= w_dx_next;
            r_dy_neg <= w_dy_next;
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/vga_rect_animator.sv
// Multi-rectangle animation engine: moves rectangles during vertical blanking
// and paints them with fixed priority into a registered RGB222 pixel stream.
module vga_rect_animator
    import vga_pkg::*;
#(
    parameter int NUM_RECTS      = 4,
    parameter int RECT_W         = 64,
    parameter int RECT_H         = 48,
    parameter int STEP           = 2,
    parameter int FRAME_DIV_BITS = 0,
    parameter int X0             = 32,
    parameter int X_SPACING      = 128,
    parameter int Y0             = 40,
    parameter int Y_SPACING      = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] i_pix_x,
    input  logic [9:0] i_pix_y,
    input  logic       i_video_active,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_run,
    input  logic       i_step,
    input  logic       i_mode,
    output logic [5:0] o_rgb,
    output logic       o_hsync,
    output logic       o_vsync
);

    localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

    logic                 w_frame_evt;
    logic                 w_div_zero;
    logic                 w_step_rise;
    logic                 w_move;
    logic                 r_step_meta;
    logic                 r_step_sync;
    logic                 r_step_prev;
    logic                 r_step_pending;
    logic [9:0]           w_x [NUM_RECTS];
    logic [9:0]           w_y [NUM_RECTS];
    logic [NUM_RECTS-1:0] w_hit;
    rgb222_t              w_colour;
    rgb222_t              r_rgb;
    logic                 r_hsync;
    logic                 r_vsync;

    // First blanking pixel: positions only change here, so no frame tears.
    assign w_frame_evt = (i_pix_x == 10'd0) && (i_pix_y == 10'(V_ACTIVE));

    generate
        if (FRAME_DIV_BITS > 0) begin : g_div
            logic [FRAME_DIV_BITS-1:0] r_div;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)           r_div <= '0;
                else if (w_frame_evt) r_div <= r_div + FRAME_DIV_BITS'(1);
            end
            assign w_div_zero = (r_div == '0);
        end else begin : g_nodiv
            assign w_div_zero = 1'b1;
        end
    endgenerate

    assign w_step_rise = r_step_sync & ~r_step_prev;
    assign w_move      = w_frame_evt & ((i_run & w_div_zero) | (~i_run & r_step_pending));

    // A pending step is consumed by a paused frame event; an edge landing on
    // that same cycle re-arms it instead of being lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_meta    <= 1'b0;
            r_step_sync    <= 1'b0;
            r_step_prev    <= 1'b0;
            r_step_pending <= 1'b0;
        end else begin
            r_step_meta <= i_step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
            if (i_run)                                  r_step_pending <= 1'b0;
            else if (w_frame_evt && r_step_pending)     r_step_pending <= w_step_rise;
            else if (w_step_rise)                       r_step_pending <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_rect
            vga_rect_mover #(
                .RECT_W      (RECT_W),
                .RECT_H      (RECT_H),
                .STEP        (STEP),
                .INIT_X      (10'(X0 + gi * X_SPACING)),
                .INIT_Y      (10'(Y0 + gi * Y_SPACING)),
                .INIT_DY_NEG ((gi % 2) == 1)
            ) u_mover (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_move (w_move),
                .i_mode (i_mode),
                .o_x    (w_x[gi]),
                .o_y    (w_y[gi])
            );

            assign w_hit[gi] = (i_pix_x >= w_x[gi])
                            && ({1'b0, i_pix_x} < ({1'b0, w_x[gi]} + 11'(RECT_W)))
                            && (i_pix_y >= w_y[gi])
                            && ({1'b0, i_pix_y} < ({1'b0, w_y[gi]} + 11'(RECT_H)));
        end
    endgenerate

    // Scan from the highest index down so the lowest hit index wins.
    always_comb begin
        w_colour = '0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (w_hit[IDX_W'(i)]) w_colour = PALETTE[3'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb   <= '0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_rgb   <= i_video_active ? w_colour : '0;
            r_hsync <= i_hsync;
            r_vsync <= i_vsync;
        end
    end

    assign o_rgb   = r_rgb;
    assign o_hsync = r_hsync;
    assign o_vsync = r_vsync;

endmodule
